// File: rtl/chunk_serial_addsub.sv
// Multi-cycle adder/subtractor: one CHUNK-bit ripple slice per clock, carry kept
// in a register between slices, start/busy/done handshake with registered results.
module chunk_serial_addsub #(
    parameter int WIDTH = 16,
    parameter int CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / CHUNK;
    localparam int KW = (N > 1) ? $clog2(N) : 1;

    generate
        if (WIDTH < 1 || CHUNK < 1 || CHUNK > WIDTH || (WIDTH % CHUNK) != 0) begin : g_param_check
            $error("chunk_serial_addsub: need 1 <= CHUNK <= WIDTH and WIDTH %% CHUNK == 0");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t             state_reg, state_next;
    logic [WIDTH-1:0]   a_reg, b_reg, work_reg, work_next;
    logic               carry_reg;
    logic [KW-1:0]      k_reg;
    logic [CHUNK:0]     c;
    logic [CHUNK-1:0]   s;
    logic               load, step, last;

    // Operands shift right each cycle so the active chunk always sits at bit 0.
    assign c[0] = carry_reg;
    generate
        for (genvar gi = 0; gi < CHUNK; gi++) begin : g_fa
            assign s[gi]   = a_reg[gi] ^ b_reg[gi] ^ c[gi];
            assign c[gi+1] = (a_reg[gi] & b_reg[gi]) | (c[gi] & (a_reg[gi] ^ b_reg[gi]));
        end
    endgenerate

    // Results enter at the top and shift down; after N steps chunk k lands at k*CHUNK.
    assign work_next = (work_reg >> CHUNK) | (WIDTH'(s) << (WIDTH - CHUNK));
    assign busy      = (state_reg == RUN);

    always_comb begin
        state_next = state_reg;
        load       = 1'b0;
        step       = 1'b0;
        last       = (k_reg == KW'(N - 1));
        case (state_reg)
            IDLE: begin
                if (start) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                step = 1'b1;
                if (last) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            k_reg     <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            work_reg  <= '0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
            done      <= 1'b0;
        end else begin
            state_reg <= state_next;
            done      <= step && last;
            if (load) begin
                a_reg     <= a;
                b_reg     <= sub ? ~b : b;
                carry_reg <= sub ? 1'b1 : cin;
                k_reg     <= '0;
            end
            if (step) begin
                a_reg     <= a_reg >> CHUNK;
                b_reg     <= b_reg >> CHUNK;
                work_reg  <= work_next;
                carry_reg <= c[CHUNK];
                k_reg     <= k_reg + 1'b1;
                if (last) begin
                    sum  <= work_next;
                    cout <= c[CHUNK];
                    ovf  <= c[CHUNK] ^ c[CHUNK-1];
                end
            end
        end
    end

endmodule

// File: tb/tb_chunk_serial_addsub.sv
// Bench for chunk_serial_addsub: directed checks on a 16/4 instance plus random
// sweeps over several WIDTH/CHUNK instances against an arithmetic reference.
module tb_chunk_serial_addsub;

    localparam int NI = 5;

    function automatic int wof(int i);
        case (i)
            0: return 16;
            1: return 16;
            2: return 16;
            3: return 8;
            default: return 32;
        endcase
    endfunction

    function automatic int cof(int i);
        case (i)
            0: return 4;
            1: return 16;
            2: return 1;
            3: return 2;
            default: return 8;
        endcase
    endfunction

    logic        clk = 1'b0;
    logic        rst;
    logic        start_s [NI];
    logic        sub_s   [NI];
    logic        cin_s   [NI];
    logic [31:0] a_s     [NI];
    logic [31:0] b_s     [NI];
    logic        busy_s  [NI];
    logic        done_s  [NI];
    logic        cout_s  [NI];
    logic        ovf_s   [NI];
    logic [31:0] sum_s   [NI];

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    generate
        for (genvar gi = 0; gi < NI; gi++) begin : g_dut
            localparam int W = wof(gi);
            localparam int C = cof(gi);
            logic [W-1:0] sum_w;
            logic         busy_w, done_w, cout_w, ovf_w;
            chunk_serial_addsub #(.WIDTH(W), .CHUNK(C)) u_dut (
                .clk   (clk),
                .rst   (rst),
                .start (start_s[gi]),
                .sub   (sub_s[gi]),
                .a     (a_s[gi][W-1:0]),
                .b     (b_s[gi][W-1:0]),
                .cin   (cin_s[gi]),
                .busy  (busy_w),
                .done  (done_w),
                .sum   (sum_w),
                .cout  (cout_w),
                .ovf   (ovf_w)
            );
            assign sum_s[gi]  = 32'(sum_w);
            assign busy_s[gi] = busy_w;
            assign done_s[gi] = done_w;
            assign cout_s[gi] = cout_w;
            assign ovf_s[gi]  = ovf_w;
        end
    endgenerate

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Reference: plain integer arithmetic and sign rules.
    function automatic void model(input int w, input bit sb, input logic [31:0] av, input logic [31:0] bv,
                                  input bit ci, output logic [31:0] s, output bit co, output bit ov);
        longint unsigned mask, am, bm, t;
        bit sa, sbb, ss;
        mask = (64'd1 << w) - 64'd1;
        am   = 64'(av) & mask;
        bm   = 64'(bv) & mask;
        if (!sb) begin
            t  = am + bm + longint'(ci);
            co = t[w];
            t  = t & mask;
        end else begin
            t  = (am - bm) & mask;
            co = (am >= bm);
        end
        s   = 32'(t);
        sa  = am[w-1];
        sbb = bm[w-1];
        ss  = t[w-1];
        ov  = sb ? (sa != sbb && ss != sa) : (sa == sbb && ss != sa);
    endfunction

    task automatic run_op(input int idx, input bit sb, input logic [31:0] av, input logic [31:0] bv,
                          input bit ci, output logic [31:0] s, output bit co, output bit ov);
        int          w, n, cyc, busy_cnt;
        logic [31:0] es, held;
        bit          eco, eov;
        w = wof(idx);
        n = w / cof(idx);
        model(w, sb, av, bv, ci, es, eco, eov);
        held         = sum_s[idx];
        start_s[idx] = 1'b1;
        sub_s[idx]   = sb;
        a_s[idx]     = av;
        b_s[idx]     = bv;
        cin_s[idx]   = ci;
        tick;
        start_s[idx] = 1'b0;
        a_s[idx]     = $urandom;
        b_s[idx]     = $urandom;
        sub_s[idx]   = 1'($urandom);
        cin_s[idx]   = 1'($urandom);
        cyc          = 0;
        busy_cnt     = 0;
        while (!done_s[idx] && cyc < n + 4) begin
            if (busy_s[idx]) busy_cnt++;
            chk($sformatf("i%0d_sum_hold", idx), sum_s[idx], held);
            tick;
            cyc++;
        end
        chk($sformatf("i%0d_latency", idx), cyc, n);
        chk($sformatf("i%0d_busy_cycles", idx), busy_cnt, n);
        chk($sformatf("i%0d_busy_at_done", idx), busy_s[idx], 0);
        chk($sformatf("i%0d_sum a=%0h b=%0h sub=%0d", idx, av, bv, sb), sum_s[idx], es);
        chk($sformatf("i%0d_cout", idx), cout_s[idx], eco);
        chk($sformatf("i%0d_ovf", idx), ovf_s[idx], eov);
        s  = sum_s[idx];
        co = cout_s[idx];
        ov = ovf_s[idx];
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0]     s, av, bv;
        bit              co, ov, sb, ci;
        int              cyc, w;
        longint unsigned mask;

        rst = 1'b1;
        for (int i = 0; i < NI; i++) begin
            start_s[i] = 1'b0;
            sub_s[i]   = 1'b0;
            cin_s[i]   = 1'b0;
            a_s[i]     = '0;
            b_s[i]     = '0;
        end
        tick;
        tick;
        chk("rst_busy", busy_s[0], 0);
        chk("rst_done", done_s[0], 0);
        chk("rst_sum", sum_s[0], 0);
        chk("rst_cout", cout_s[0], 0);
        chk("rst_ovf", ovf_s[0], 0);
        rst = 1'b0;
        tick;

        run_op(0, 0, 32'h1234, 32'h4321, 0, s, co, ov);
        chk("basic_sum", s, 32'h5555);
        chk("basic_cout", co, 0);
        chk("basic_ovf", ov, 0);
        tick;
        chk("done_one_cycle", done_s[0], 0);

        run_op(0, 0, 32'hFFFF, 32'h0000, 1, s, co, ov);
        chk("cin_sum", s, 32'h0000);
        chk("cin_cout", co, 1);
        chk("cin_ovf", ov, 0);

        run_op(0, 0, 32'h7FFF, 32'h0001, 0, s, co, ov);
        chk("addovf_sum", s, 32'h8000);
        chk("addovf_cout", co, 0);
        chk("addovf_ovf", ov, 1);

        for (int c = 0; c < 2; c++) begin
            run_op(0, 1, 32'h0005, 32'h0007, 1'(c), s, co, ov);
            chk($sformatf("sub1_sum_cin%0d", c), s, 32'hFFFE);
            chk($sformatf("sub1_cout_cin%0d", c), co, 0);
            chk($sformatf("sub1_ovf_cin%0d", c), ov, 0);
            run_op(0, 1, 32'h8000, 32'h0001, 1'(c), s, co, ov);
            chk($sformatf("sub2_sum_cin%0d", c), s, 32'h7FFF);
            chk($sformatf("sub2_cout_cin%0d", c), co, 1);
            chk($sformatf("sub2_ovf_cin%0d", c), ov, 1);
        end

        // Back-to-back: second start presented in the done cycle of the first.
        run_op(0, 0, 32'h1111, 32'h2222, 0, s, co, ov);
        run_op(0, 0, 32'h0001, 32'h0001, 0, s, co, ov);
        chk("b2b_sum", s, 32'h0002);

        // Start during RUN must be ignored.
        tick;
        start_s[0] = 1'b1; sub_s[0] = 1'b0; cin_s[0] = 1'b0;
        a_s[0] = 32'h1234; b_s[0] = 32'h4321;
        tick;
        start_s[0] = 1'b0;
        tick;
        start_s[0] = 1'b1; sub_s[0] = 1'b1; a_s[0] = 32'hFFFF; b_s[0] = 32'hFFFF;
        tick;
        start_s[0] = 1'b0;
        cyc = 2;
        while (!done_s[0] && cyc < 10) begin
            tick;
            cyc++;
        end
        chk("ign_latency", cyc, 4);
        chk("ign_sum", sum_s[0], 32'h5555);
        chk("ign_cout", cout_s[0], 0);
        tick;
        chk("ign_no_queue_done", done_s[0], 0);
        chk("ign_no_queue_busy", busy_s[0], 0);

        // Abort mid-operation with reset after non-zero flags were produced.
        run_op(0, 1, 32'h8000, 32'h0001, 0, s, co, ov);
        tick;
        start_s[0] = 1'b1; sub_s[0] = 1'b0; cin_s[0] = 1'b0;
        a_s[0] = 32'h1234; b_s[0] = 32'h4321;
        tick;
        start_s[0] = 1'b0;
        tick;
        rst = 1'b1;
        tick;
        rst = 1'b0;
        chk("abort_busy", busy_s[0], 0);
        chk("abort_done", done_s[0], 0);
        chk("abort_sum", sum_s[0], 0);
        chk("abort_cout", cout_s[0], 0);
        chk("abort_ovf", ovf_s[0], 0);
        for (int i = 0; i < 10; i++) begin
            tick;
            chk($sformatf("abort_no_done_%0d", i), done_s[0], 0);
        end

        // Random sweep over every geometry, with corner operands first.
        for (int idx = 0; idx < NI; idx++) begin
            w    = wof(idx);
            mask = (64'd1 << w) - 64'd1;
            for (int j = 0; j < 12; j++) begin
                case (j)
                    0: begin av = 32'(mask); bv = 32'(mask); sb = 0; ci = 1; end
                    1: begin av = 0; bv = 32'(mask); sb = 1; ci = 0; end
                    2: begin av = 32'(64'd1 << (w - 1)); bv = 1; sb = 1; ci = 1; end
                    default: begin
                        av = $urandom & 32'(mask);
                        bv = $urandom & 32'(mask);
                        sb = 1'($urandom);
                        ci = 1'($urandom);
                    end
                endcase
                run_op(idx, sb, av, bv, ci, s, co, ov);
            end
            tick;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
